// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-to-ALU command sequencer.
package uart_alu_pkg;

  // Sequencer states. The numeric values are visible on the STATE debug port.
  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_t;

  // Byte sent back in place of a result when a partial frame is dropped.
  localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

endpackage

// File: rtl/uart_alu_ctrl_frame_timer.sv
// Inter-byte timeout counter for a partially received frame.
module frame_timer #(
  parameter int TO_BIT      = 22,
  parameter int TIMEOUT_CYC = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_BIT-1:0] cnt;

  // Count idle cycles; clear has priority so a captured byte restarts the window.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + TO_BIT'(1);
  end

  // Last idle cycle of the window; the caller qualifies it with its own enable.
  assign expired = (cnt == TO_BIT'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_alu_ctrl.sv
// Sequencer between the UART FIFOs and a combinational ALU: pops A, B, opcode,
// executes, pushes one result byte, and drops stalled partial frames.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int                N_BIT       = 8,
  parameter int                OP_BIT      = 6,
  parameter int                TIMEOUT_CYC = 2_500_000,
  parameter int                TO_BIT      = 22,
  parameter logic [N_BIT-1:0]  ERR_BYTE    = N_BIT'(ERR_BYTE_DEFAULT)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              rx_empty,
  input  logic [N_BIT-1:0]  r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [N_BIT-1:0]  w_data,
  output logic [N_BIT-1:0]  alu_a,
  output logic [N_BIT-1:0]  alu_b,
  output logic [OP_BIT-1:0] alu_op,
  input  logic [N_BIT-1:0]  alu_result,
  output logic              busy,
  output logic              frame_err,
  output logic [2:0]        STATE
);

  state_t            state, next_state;
  logic [N_BIT-1:0]  result;
  logic              in_frame;   // waiting for B or opcode; the timeout applies
  logic              timer_exp;
  logic              timeout;

  assign in_frame = (state == GET_B) || (state == GET_OP);
  // A byte present this cycle always beats the timeout.
  assign timeout  = in_frame && rx_empty && timer_exp;

  frame_timer #(
    .TO_BIT      (TO_BIT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_timer (
    .clk     (CLK),
    .rst_n   (RESET),
    .clr     (!in_frame || !rx_empty),
    .en      (in_frame && rx_empty),
    .expired (timer_exp)
  );

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= GET_A;
    else        state <= next_state;
  end

  // Next-state decode.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      GET_A:  if (!rx_empty) next_state = GET_B;
      GET_B:  if (!rx_empty) next_state = GET_OP;
              else if (timeout) next_state = SEND;
      GET_OP: if (!rx_empty) next_state = EXEC;
              else if (timeout) next_state = SEND;
      EXEC:   next_state = SEND;
      SEND:   if (!tx_full) next_state = GET_A;
      default: next_state = GET_A;
    endcase
  end

  // FIFO handshakes and status; gated by reset so nothing pops or pushes in reset.
  always_comb begin
    rd_uart = 1'b0;
    wr_uart = 1'b0;
    busy    = (state != GET_A);
    if (RESET) begin
      rd_uart = !rx_empty && (state == GET_A || state == GET_B || state == GET_OP);
      wr_uart = !tx_full && (state == SEND);
    end
  end

  // Operand capture, result latch and the registered frame-error pulse.
  // NOTE: these registers are all reset explicitly; outputs must read 0 out of reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      result    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= timeout;
      if (state == GET_A && !rx_empty)  alu_a  <= r_data;
      if (state == GET_B && !rx_empty)  alu_b  <= r_data;
      if (state == GET_OP && !rx_empty) alu_op <= r_data[OP_BIT-1:0];
      if (state == EXEC)                result <= alu_result;
      else if (timeout)                 result <= ERR_BYTE;
    end
  end

  assign w_data = result;
  assign STATE  = state;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with FIFO and ALU models around the DUT.
module tb_uart_alu_ctrl;

  localparam int N_BIT  = 8;
  localparam int OP_BIT = 6;
  localparam int TO_CYC = 16;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              rx_empty = 1'b1;
  logic [N_BIT-1:0]  r_data = '0;
  logic              rd_uart;
  logic              tx_full;
  logic              wr_uart;
  logic [N_BIT-1:0]  w_data;
  logic [N_BIT-1:0]  alu_a, alu_b;
  logic [OP_BIT-1:0] alu_op;
  logic [N_BIT-1:0]  alu_result;
  logic              busy, frame_err;
  logic [2:0]        STATE;

  uart_alu_ctrl #(
    .N_BIT       (N_BIT),
    .OP_BIT      (OP_BIT),
    .TIMEOUT_CYC (TO_CYC),
    .TO_BIT      (5),
    .ERR_BYTE    (8'hEE)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .rx_empty   (rx_empty),
    .r_data     (r_data),
    .rd_uart    (rd_uart),
    .tx_full    (tx_full),
    .wr_uart    (wr_uart),
    .w_data     (w_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .busy       (busy),
    .frame_err  (frame_err),
    .STATE      (STATE)
  );

  always #5 CLK = ~CLK;

  // External ALU model: a small fixed opcode set.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      6'h20: alu_result = alu_a + alu_b;
      6'h22: alu_result = alu_a - alu_b;
      6'h24: alu_result = alu_a & alu_b;
      6'h25: alu_result = alu_a | alu_b;
      6'h26: alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
  end

  // FIFO models; flags change only at the clock edge, after the pop/push.
  logic [7:0] rx_q[$];
  logic [7:0] push_data[$];
  int         push_cyc[$];
  int         pop_cyc[$];
  int         cyc = 0;
  int         fe_cnt = 0;
  int         fe_cyc = 0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (rd_uart && rx_q.size() > 0) begin
      pop_cyc.push_back(cyc + 1);
      void'(rx_q.pop_front());
    end
    rx_empty <= (rx_q.size() == 0);
    r_data   <= (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    if (wr_uart) begin
      push_data.push_back(w_data);
      push_cyc.push_back(cyc + 1);
    end
  end

  always @(negedge CLK) begin
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    push_data.delete();
    push_cyc.delete();
    pop_cyc.delete();
  endtask

  task automatic wait_push(input int n, input int budget);
    int k = 0;
    while (push_data.size() < n && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (push_data.size() < n) check("wait_push_timeout", push_data.size(), n);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int k = 0;
    while (STATE !== s && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (STATE !== s) check("wait_state_timeout", STATE, s);
  endtask

  function automatic logic [7:0] pushed(input int i);
    return (push_data.size() > i) ? push_data[i] : 8'hXX;
  endfunction

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op_byte;
    logic [5:0] exp_op;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c0;
    int bad;
    int fe_base;

    vecs[0] = '{a: 8'h0C, b: 8'h0A, op_byte: 8'h22, exp_op: 6'h22, exp_res: 8'h02};
    vecs[1] = '{a: 8'hF0, b: 8'h3C, op_byte: 8'h24, exp_op: 6'h24, exp_res: 8'h30};
    vecs[2] = '{a: 8'hF0, b: 8'h0F, op_byte: 8'h25, exp_op: 6'h25, exp_res: 8'hFF};
    vecs[3] = '{a: 8'hAA, b: 8'hFF, op_byte: 8'h26, exp_op: 6'h26, exp_res: 8'h55};
    vecs[4] = '{a: 8'h05, b: 8'h03, op_byte: 8'hE0, exp_op: 6'h20, exp_res: 8'h08};
    vecs[5] = '{a: 8'hFF, b: 8'h02, op_byte: 8'h60, exp_op: 6'h20, exp_res: 8'h01};

    // Reset state, with a frame already waiting in the RX FIFO.
    RESET   = 1'b0;
    tx_full = 1'b0;
    rx_q.push_back(8'h05);
    rx_q.push_back(8'h03);
    rx_q.push_back(8'h20);
    repeat (3) @(negedge CLK);
    check("rst_state",     STATE,     3'd0);
    check("rst_alu_a",     alu_a,     8'h00);
    check("rst_alu_b",     alu_b,     8'h00);
    check("rst_alu_op",    alu_op,    6'h00);
    check("rst_w_data",    w_data,    8'h00);
    check("rst_rd_uart",   rd_uart,   1'b0);
    check("rst_wr_uart",   wr_uart,   1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_frame_err", frame_err, 1'b0);

    // First frame: 5 + 3 with op 0x20, result pushed 2 cycles after the opcode pop.
    RESET = 1'b1;
    wait_push(1, 20);
    check("f1_alu_a",    alu_a,  8'h05);
    check("f1_alu_b",    alu_b,  8'h03);
    check("f1_alu_op",   alu_op, 6'h20);
    check("f1_result",   pushed(0), 8'h08);
    check("f1_pops",     pop_cyc.size(), 3);
    if (pop_cyc.size() == 3 && push_cyc.size() == 1)
      check("f1_latency", push_cyc[0] - pop_cyc[2], 2);
    @(negedge CLK);
    check("f1_single_push", push_data.size(), 1);

    // Two frames back-to-back: 6 pops, 2 pushes within 10 cycles.
    clear_logs();
    rx_q.push_back(8'h01); rx_q.push_back(8'h02); rx_q.push_back(8'h20);
    rx_q.push_back(8'h30); rx_q.push_back(8'h18); rx_q.push_back(8'h24);
    wait_push(2, 40);
    check("b2b_pops",  pop_cyc.size(), 6);
    check("b2b_res0",  pushed(0), 8'h03);
    check("b2b_res1",  pushed(1), 8'h10);
    if (pop_cyc.size() == 6 && push_cyc.size() == 2)
      check("b2b_span", push_cyc[1] - pop_cyc[0], 9);

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      clear_logs();
      rx_q.push_back(vecs[i].a);
      rx_q.push_back(vecs[i].b);
      rx_q.push_back(vecs[i].op_byte);
      wait_push(1, 20);
      check($sformatf("vec%0d_alu_a", i),  alu_a,     vecs[i].a);
      check($sformatf("vec%0d_alu_b", i),  alu_b,     vecs[i].b);
      check($sformatf("vec%0d_alu_op", i), alu_op,    vecs[i].exp_op);
      check($sformatf("vec%0d_result", i), pushed(0), vecs[i].exp_res);
      @(negedge CLK);
    end

    // Timeout: operand A only, then silence.
    clear_logs();
    fe_base = fe_cnt;
    rx_q.push_back(8'h05);
    wait_push(1, 60);
    @(negedge CLK);
    check("to_err_byte",  pushed(0), 8'hEE);
    check("to_pulses",    fe_cnt - fe_base, 1);
    if (pop_cyc.size() == 1)
      check("to_delay", fe_cyc - pop_cyc[0], TO_CYC);
    check("to_state",     STATE, 3'd0);
    check("to_stale_a",   alu_a, 8'h05);
    clear_logs();
    rx_q.push_back(8'h07); rx_q.push_back(8'h02); rx_q.push_back(8'h22);
    wait_push(1, 20);
    check("to_next_frame", pushed(0), 8'h05);
    @(negedge CLK);

    // TX FIFO full for 20 cycles while in SEND.
    clear_logs();
    tx_full = 1'b1;
    rx_q.push_back(8'h09); rx_q.push_back(8'h04); rx_q.push_back(8'h20);
    wait_state(3'd4, 20);
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (wr_uart !== 1'b0 || STATE !== 3'd4) bad++;
    end
    check("full_hold",    bad, 0);
    check("full_no_push", push_data.size(), 0);
    tx_full = 1'b0;
    c0 = cyc;
    wait_push(1, 10);
    check("full_result",  pushed(0), 8'h0D);
    if (push_cyc.size() == 1)
      check("full_release", push_cyc[0], c0 + 1);
    @(negedge CLK);

    // Reset mid-frame after operand A.
    clear_logs();
    fe_base = fe_cnt;
    rx_q.push_back(8'h11);
    wait_state(3'd1, 10);
    check("mid_alu_a", alu_a, 8'h11);
    #2;
    RESET = 1'b0;
    #1;
    check("mid_rst_state",  STATE,   3'd0);
    check("mid_rst_alu_a",  alu_a,   8'h00);
    check("mid_rst_busy",   busy,    1'b0);
    check("mid_rst_w_data", w_data,  8'h00);
    @(negedge CLK);
    RESET = 1'b1;
    rx_q.push_back(8'h01); rx_q.push_back(8'h02); rx_q.push_back(8'h20);
    wait_push(1, 30);
    repeat (3) @(negedge CLK);
    check("mid_fresh_result", pushed(0), 8'h03);
    check("mid_push_count",   push_data.size(), 1);
    check("mid_no_frame_err", fe_cnt - fe_base, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Command sequencer between the UART's RX/TX FIFOs and the combinational ALU. It pops a three-byte frame from the RX FIFO: operand A, operand B, then opcode. It presents the frame to the ALU, registers the result and pushes one result byte into the TX FIFO. A frame-timeout counter discards partial frames and reports them with an error byte, so a lost byte on the serial line cannot desynchronise the operand stream.

## Interface
Parameters:
- N_BIT, 8, data/operand width (matches UART word).
- OP_BIT, 6, ALU opcode width; taken from r_data[OP_BIT-1:0] of the opcode byte.
- TIMEOUT_CYC, 2_500_000, idle CLK cycles allowed between bytes of one frame (50 ms at 50 MHz).
- TO_BIT, 22, timeout counter width; must satisfy 2^TO_BIT > TIMEOUT_CYC.
- ERR_BYTE, 8'hEE, byte sent to TX FIFO on frame timeout.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- rx_empty  in  1  RX FIFO empty flag.
- r_data  in  N_BIT  RX FIFO head word (first-word-fall-through, valid while rx_empty=0).
- rd_uart  out  1  RX FIFO pop; pops at the same edge the byte is captured.
- tx_full  in  1  TX FIFO full flag.
- wr_uart  out  1  TX FIFO push.
- w_data  out  N_BIT  TX FIFO write data.
- alu_a, alu_b  out  N_BIT  registered operands.
- alu_op  out  OP_BIT  registered opcode.
- alu_result  in  N_BIT  ALU combinational result.
- busy  out  1  high in any state except GET_A.
- frame_err  out  1  one-cycle pulse when a partial frame is discarded.
- STATE  out  3  current state encoding, for debug.

## Operation
- States: GET_A, GET_B, GET_OP, EXEC, SEND. The reset state is GET_A.
- GET_A: if rx_empty=0, capture r_data into alu_a, rd_uart=1, then go to GET_B. The timeout counter is idle here, so there is no limit on the wait for a new frame.
- GET_B: if rx_empty=0, capture into alu_b, rd_uart=1, then go to GET_OP.
- GET_OP: if rx_empty=0, capture r_data[OP_BIT-1:0] into alu_op, rd_uart=1, then go to EXEC. Upper opcode-byte bits are ignored.
- EXEC: one cycle. Latch alu_result into the result register, then go to SEND.
- SEND: w_data = result register. If tx_full=0, wr_uart=1 and go to GET_A; otherwise hold in SEND indefinitely, with no timeout.
- Timeout:
  - The counter clears on entry to GET_B and on each captured byte.
  - It increments every cycle in GET_B or GET_OP while rx_empty=1.
  - When it reaches TIMEOUT_CYC-1 with rx_empty=1: load the result register with ERR_BYTE, pulse frame_err, go to SEND.
  - alu_a, alu_b and alu_op keep their stale values.
- If a byte arrives in the same cycle the timeout would fire, the byte wins and the counter clears.
- rd_uart and wr_uart are combinational decodes of state and the FIFO flags, forced to 0 while RESET=0. The FIFO flags update after the pop/push edge, so double pops are impossible.

## Timing
- Reset values:
  - state GET_A, STATE=0.
  - alu_a, alu_b, alu_op, result register, w_data all 0.
  - rd_uart=0, wr_uart=0, busy=0, frame_err=0.
  - timeout counter 0.
- Per-byte latency: a byte is captured and popped in the first cycle it is visible with rx_empty=0.
- Opcode pop edge to wr_uart high: 2 cycles (EXEC, then SEND), given tx_full=0.
- Frame throughput with bytes back-to-back in the FIFO: 5 cycles per frame.
- Timeout fires exactly TIMEOUT_CYC cycles after the last capture edge, with rx_empty held 1.
- A reset asserted mid-frame returns to GET_A immediately, discarding the partial frame; no ERR_BYTE is sent.

## Structure
- Package uart_alu_pkg holds:
  - the state encoding constants (GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SEND=4).
  - the default ERR_BYTE.
- One sub-module, frame_timer (TO_BIT, TIMEOUT_CYC), with ports clr, en and expired (combinational compare). The FSM and operand registers stay in uart_alu_ctrl.

## Test plan
- RX FIFO preloaded with 8'h05, 8'h03, 8'h20 and the ALU modelled as ADD for op 6'h20 -> alu_a=5, alu_b=3, alu_op=6'h20; one wr_uart pulse with w_data=8'h08, exactly 2 cycles after the third pop.
- Two frames preloaded back-to-back -> 6 pops and 2 pushes in 10 cycles; results in order.
- TIMEOUT_CYC=16; send 8'h05 only -> frame_err pulses 16 cycles after the pop; w_data=8'hEE pushed; state returns to GET_A; a following full frame is processed correctly.
- tx_full=1 held 20 cycles during SEND -> wr_uart stays 0 and the state stays SEND; the push occurs the first cycle after tx_full falls, with the result unchanged.
- Opcode byte 8'hE0 -> alu_op=6'h20 (upper bits dropped).
- RESET pulsed low after operand A is captured -> all outputs return to reset values asynchronously; the next three bytes form a fresh frame.
